// File: rtl/multicycle_wb_scheduler.sv
// -----------------------------------------------------------------------------
// multicycle_wb_scheduler
//
// Purpose:
//   Runs the three shared multicycle execution units (fsqrt, div, fdiv) from
//   issue to writeback. Each unit has a slot FSM that records the destination
//   register and the unit result. The scheduler also arbitrates the single
//   spare register-file writeback slot between the units that have finished.
//
// Optional feature (compile-time macro):
//   MC_RR_ARB_EN  defined   : round-robin grant, starting after the last
//                             granted unit (fsqrt -> div -> fdiv -> fsqrt)
//                 undefined : fixed priority div > fdiv > fsqrt
//
// Ports:
//   clk                 core clock
//   reset               synchronous, active-high reset
//   p_signal_start_exe  issue strobes {fdiv, div, fsqrt}; at most one bit set
//   start_rd            destination register of the issuing instruction
//   start_fp            destination is the FP register file
//   unit_done           completion pulses {fdiv, div, fsqrt}
//   fsqrt_result        fsqrt result, valid with unit_done[0]
//   div_result          div/rem result, valid with unit_done[1]
//   fdiv_result         fdiv result, valid with unit_done[2]
//   wb_slot_free        main pipeline leaves the register file write port free
//   wb_valid            scheduler writes the register file this cycle
//   wb_rd / wb_fp       writeback destination and register-file select
//   wb_data             writeback data
//   wb_unit             one-hot granted unit, 0 when wb_valid = 0
//   *_unit_busy         the unit's slot is not IDLE
//   issue_err           sticky: a start arrived for a slot that was not IDLE
//
// Handshake: a slot in DONE presents a writeback request that is held until
// it is granted. A grant only happens in a cycle where wb_slot_free = 1, and
// the slot returns to IDLE on the edge that ends the granted cycle.
// -----------------------------------------------------------------------------
module multicycle_wb_scheduler #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      p_signal_start_exe,
  input  logic [4:0]      start_rd,
  input  logic            start_fp,
  input  logic [2:0]      unit_done,
  input  logic [XLEN-1:0] fsqrt_result,
  input  logic [XLEN-1:0] div_result,
  input  logic [XLEN-1:0] fdiv_result,
  input  logic            wb_slot_free,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic            wb_fp,
  output logic [XLEN-1:0] wb_data,
  output logic [2:0]      wb_unit,
  output logic            fsqrt_unit_busy,
  output logic            div_unit_busy,
  output logic            fdiv_unit_busy,
  output logic            issue_err
);

  // Slot index order matches the strobe bit order: 0 fsqrt, 1 div, 2 fdiv.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } slot_state_t;

  slot_state_t     r_state     [0:2];
  slot_state_t     w_state_nxt [0:2];
  logic [4:0]      r_rd        [0:2];
  logic            r_fp        [0:2];
  logic [XLEN-1:0] r_data      [0:2];
  logic [XLEN-1:0] w_result    [0:2];
  logic            r_issue_err;
  logic            w_err_set;
  logic [2:0]      w_cand;
  logic [2:0]      w_grant;

  assign w_result[0] = fsqrt_result;
  assign w_result[1] = div_result;
  assign w_result[2] = fdiv_result;

  // ---------------------------------------------------------------------------
  // Slot next-state logic. A start on a non-IDLE slot is dropped and flagged.
  // In RUN, a done pulse wins over a colliding start.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_err_set = 1'b0;
    for (int u = 0; u < 3; u++) begin
      w_state_nxt[u] = r_state[u];
      case (r_state[u])
        S_IDLE: begin
          if (p_signal_start_exe[u]) w_state_nxt[u] = S_RUN;
        end
        S_RUN: begin
          if (unit_done[u])          w_state_nxt[u] = S_DONE;
          if (p_signal_start_exe[u]) w_err_set      = 1'b1;
        end
        S_DONE: begin
          if (w_grant[u])            w_state_nxt[u] = S_IDLE;
          if (p_signal_start_exe[u]) w_err_set      = 1'b1;
        end
        default: w_state_nxt[u] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int u = 0; u < 3; u++) begin
        r_state[u] <= S_IDLE;
        r_rd[u]    <= '0;
        r_fp[u]    <= 1'b0;
        r_data[u]  <= '0;
      end
      r_issue_err <= 1'b0;
    end else begin
      for (int u = 0; u < 3; u++) begin
        r_state[u] <= w_state_nxt[u];
        if (r_state[u] == S_IDLE && p_signal_start_exe[u]) begin
          r_rd[u] <= start_rd;
          r_fp[u] <= start_fp;
        end
        if (r_state[u] == S_RUN && unit_done[u]) begin
          r_data[u] <= w_result[u];
        end
      end
      r_issue_err <= r_issue_err | w_err_set;
    end
  end

  // ---------------------------------------------------------------------------
  // Writeback arbitration between DONE slots.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int u = 0; u < 3; u++) begin
      w_cand[u] = (r_state[u] == S_DONE);
    end
  end

`ifdef MC_RR_ARB_EN
  // Pointer holds the last granted slot index; search starts one past it.
  logic [1:0] r_rr_ptr;
  logic [1:0] w_grant_idx;

  always_comb begin
    logic found;
    int   idx;
    found       = 1'b0;
    idx         = 0;
    w_grant     = 3'b000;
    w_grant_idx = r_rr_ptr;
    if (wb_slot_free) begin
      for (int k = 1; k <= 3; k++) begin
        idx = (int'(r_rr_ptr) + k) % 3;
        if (!found && w_cand[idx]) begin
          found        = 1'b1;
          w_grant[idx] = 1'b1;
          w_grant_idx  = 2'(idx);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr <= 2'd0;
    end else if (|w_grant) begin
      r_rr_ptr <= w_grant_idx;
    end
  end
`else
  always_comb begin
    w_grant = 3'b000;
    if (wb_slot_free) begin
      if (w_cand[1])      w_grant = 3'b010;
      else if (w_cand[2]) w_grant = 3'b100;
      else if (w_cand[0]) w_grant = 3'b001;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Writeback outputs: driven from the granted slot, all zero otherwise.
  // ---------------------------------------------------------------------------
  always_comb begin
    wb_valid = 1'b0;
    wb_rd    = '0;
    wb_fp    = 1'b0;
    wb_data  = '0;
    wb_unit  = 3'b000;
    for (int u = 0; u < 3; u++) begin
      if (w_grant[u]) begin
        wb_valid = 1'b1;
        wb_rd    = r_rd[u];
        wb_fp    = r_fp[u];
        wb_data  = r_data[u];
        wb_unit  = w_grant;
      end
    end
  end

  assign fsqrt_unit_busy = (r_state[0] != S_IDLE);
  assign div_unit_busy   = (r_state[1] != S_IDLE);
  assign fdiv_unit_busy  = (r_state[2] != S_IDLE);
  assign issue_err       = r_issue_err;

endmodule

// File: tb/tb_multicycle_wb_scheduler.sv
module tb_multicycle_wb_scheduler;

  localparam int XLEN = 32;

  // ---------------------------------------------------------------------------
  // Clock / DUT
  // ---------------------------------------------------------------------------
  logic            clk;
  logic            reset;
  logic [2:0]      p_signal_start_exe;
  logic [4:0]      start_rd;
  logic            start_fp;
  logic [2:0]      unit_done;
  logic [XLEN-1:0] fsqrt_result;
  logic [XLEN-1:0] div_result;
  logic [XLEN-1:0] fdiv_result;
  logic            wb_slot_free;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic            wb_fp;
  logic [XLEN-1:0] wb_data;
  logic [2:0]      wb_unit;
  logic            fsqrt_unit_busy;
  logic            div_unit_busy;
  logic            fdiv_unit_busy;
  logic            issue_err;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  multicycle_wb_scheduler #(.XLEN(XLEN)) dut (
    .clk                (clk),
    .reset              (reset),
    .p_signal_start_exe (p_signal_start_exe),
    .start_rd           (start_rd),
    .start_fp           (start_fp),
    .unit_done          (unit_done),
    .fsqrt_result       (fsqrt_result),
    .div_result         (div_result),
    .fdiv_result        (fdiv_result),
    .wb_slot_free       (wb_slot_free),
    .wb_valid           (wb_valid),
    .wb_rd              (wb_rd),
    .wb_fp              (wb_fp),
    .wb_data            (wb_data),
    .wb_unit            (wb_unit),
    .fsqrt_unit_busy    (fsqrt_unit_busy),
    .div_unit_busy      (div_unit_busy),
    .fdiv_unit_busy     (fdiv_unit_busy),
    .issue_err          (issue_err)
  );

  // ---------------------------------------------------------------------------
  // Reference model: each unit is either free, computing, or holding a
  // finished result waiting for the register-file port.
  // ---------------------------------------------------------------------------
  localparam int FREE    = 0;
  localparam int WORKING = 1;
  localparam int READY   = 2;

  int              m_phase [3];
  logic [4:0]      m_rd    [3];
  logic            m_fp    [3];
  logic [XLEN-1:0] m_val   [3];
  logic            m_err;
  int              m_last;

  int n_checks = 0;
  int n_errors = 0;

  function automatic int model_grant();
    int order [3];
    if (!wb_slot_free) return -1;
`ifdef MC_RR_ARB_EN
    for (int k = 0; k < 3; k++) order[k] = (m_last + 1 + k) % 3;
`else
    order[0] = 1; order[1] = 2; order[2] = 0;
`endif
    for (int k = 0; k < 3; k++)
      if (m_phase[order[k]] == READY) return order[k];
    return -1;
  endfunction

  function automatic logic [XLEN-1:0] result_of(int u);
    case (u)
      0:       return fsqrt_result;
      1:       return div_result;
      default: return fdiv_result;
    endcase
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 3; u++) begin
      m_phase[u] = FREE; m_rd[u] = '0; m_fp[u] = 1'b0; m_val[u] = '0;
    end
    m_err  = 1'b0;
    m_last = 0;
  endtask

  // Advance the model by one clock edge using the inputs held at that edge.
  task automatic model_step();
    int g;
    g = model_grant();
    if (reset) begin
      model_reset();
      return;
    end
    if (g >= 0) m_last = g;
    for (int u = 0; u < 3; u++) begin
      if (m_phase[u] == FREE) begin
        if (p_signal_start_exe[u]) begin
          m_phase[u] = WORKING; m_rd[u] = start_rd; m_fp[u] = start_fp;
        end
      end else begin
        if (p_signal_start_exe[u]) m_err = 1'b1;
        if (m_phase[u] == WORKING && unit_done[u]) begin
          m_phase[u] = READY; m_val[u] = result_of(u);
        end else if (m_phase[u] == READY && g == u) begin
          m_phase[u] = FREE;
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    int g;
    logic [2:0] exp_busy;
    g = model_grant();
    for (int u = 0; u < 3; u++) exp_busy[u] = (m_phase[u] != FREE);
    chk("wb_valid",  64'(wb_valid), 64'(g >= 0));
    chk("wb_unit",   64'(wb_unit),  (g >= 0) ? 64'(1 << g) : 64'd0);
    chk("wb_rd",     64'(wb_rd),    (g >= 0) ? 64'(m_rd[g]) : 64'd0);
    chk("wb_fp",     64'(wb_fp),    (g >= 0) ? 64'(m_fp[g]) : 64'd0);
    chk("wb_data",   64'(wb_data),  (g >= 0) ? 64'(m_val[g]) : 64'd0);
    chk("busy",      64'({fdiv_unit_busy, div_unit_busy, fsqrt_unit_busy}), 64'(exp_busy));
    chk("issue_err", 64'(issue_err), 64'(m_err));
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic apply(input logic [2:0] st, input logic [4:0] rd, input logic fp,
                       input logic [2:0] dn, input logic fr, input logic rs);
    p_signal_start_exe = st;
    start_rd           = rd;
    start_fp           = fp;
    unit_done          = dn;
    wb_slot_free       = fr;
    reset              = rs;
    fsqrt_result       = $urandom;
    div_result         = $urandom;
    fdiv_result        = $urandom;
    #1;
    check_model();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input logic fr);
    apply(3'b000, 5'd0, 1'b0, 3'b000, fr, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    model_reset();
    p_signal_start_exe = '0; start_rd = '0; start_fp = 1'b0; unit_done = '0;
    fsqrt_result = '0; div_result = '0; fdiv_result = '0;
    wb_slot_free = 1'b1; reset = 1'b1;
    tick();

    // Reset state
    idle(1'b1);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_busy", 64'({fdiv_unit_busy, div_unit_busy, fsqrt_unit_busy}), 64'd0);

    // 1: div rd=5, done at c10 with 0x2A, writeback at c11
    apply(3'b010, 5'd5, 1'b0, 3'b000, 1'b1, 1'b0); tick();
    for (int c = 1; c <= 9; c++) begin
      idle(1'b1);
      chk("t1_busy_run", 64'(div_unit_busy), 64'd1);
      tick();
    end
    apply(3'b000, 5'd0, 1'b0, 3'b010, 1'b1, 1'b0);
    div_result = 32'h0000_002A;
    chk("t1_busy_c10", 64'(div_unit_busy), 64'd1);
    tick();
    idle(1'b1);
    chk("t1_wb_valid", 64'(wb_valid), 64'd1);
    chk("t1_wb_rd",    64'(wb_rd),    64'd5);
    chk("t1_wb_data",  64'(wb_data),  64'h2A);
    chk("t1_wb_unit",  64'(wb_unit),  64'b010);
    chk("t1_busy_c11", 64'(div_unit_busy), 64'd1);
    tick();
    idle(1'b1);
    chk("t1_busy_c12", 64'(div_unit_busy), 64'd0);
    tick();

    // 2: fsqrt and fdiv complete together
    apply(3'b001, 5'd3, 1'b1, 3'b000, 1'b1, 1'b0); tick();
    apply(3'b100, 5'd7, 1'b1, 3'b000, 1'b1, 1'b0); tick();
    apply(3'b000, 5'd0, 1'b0, 3'b101, 1'b1, 1'b0); tick();
    idle(1'b1);
`ifndef MC_RR_ARB_EN
    chk("t2_first_unit", 64'(wb_unit), 64'b100);
    chk("t2_first_rd",   64'(wb_rd),   64'd7);
`endif
    tick();
    idle(1'b1);
`ifndef MC_RR_ARB_EN
    chk("t2_second_unit", 64'(wb_unit), 64'b001);
    chk("t2_second_rd",   64'(wb_rd),   64'd3);
`endif
    tick();

    // 3: div DONE held off by a busy writeback port
    apply(3'b010, 5'd9, 1'b0, 3'b000, 1'b0, 1'b0); tick();
    apply(3'b000, 5'd0, 1'b0, 3'b010, 1'b0, 1'b0); tick();
    for (int c = 0; c < 4; c++) begin
      idle(1'b0);
      chk("t3_held_valid", 64'(wb_valid), 64'd0);
      chk("t3_held_busy",  64'(div_unit_busy), 64'd1);
      tick();
    end
    idle(1'b1);
    chk("t3_release_valid", 64'(wb_valid), 64'd1);
    tick();

    // 4: second div start while RUN
    apply(3'b010, 5'd12, 1'b0, 3'b000, 1'b1, 1'b0); tick();
    apply(3'b010, 5'd20, 1'b1, 3'b000, 1'b1, 1'b0); tick();
    idle(1'b1);
    chk("t4_issue_err", 64'(issue_err), 64'd1);
    tick();
    apply(3'b000, 5'd0, 1'b0, 3'b010, 1'b1, 1'b0); tick();
    idle(1'b1);
    chk("t4_rd_kept", 64'(wb_rd), 64'd12);
    tick();

    // 5: all three DONE at once, drained back to back
    apply(3'b001, 5'd1, 1'b1, 3'b000, 1'b1, 1'b0); tick();
    apply(3'b010, 5'd2, 1'b0, 3'b000, 1'b1, 1'b0); tick();
    apply(3'b100, 5'd4, 1'b1, 3'b000, 1'b1, 1'b0); tick();
    apply(3'b000, 5'd0, 1'b0, 3'b111, 1'b1, 1'b0); tick();
    for (int c = 0; c < 3; c++) begin
      idle(1'b1);
      chk("t5_no_bubble", 64'(wb_valid), 64'd1);
`ifndef MC_RR_ARB_EN
      chk("t5_order", 64'(wb_unit), (c == 0) ? 64'b010 : (c == 1) ? 64'b100 : 64'b001);
`endif
      tick();
    end
    idle(1'b1);
    chk("t4_err_sticky", 64'(issue_err), 64'd1);
    tick();

    // 6: reset while fdiv RUN, then a stale done pulse
    apply(3'b100, 5'd8, 1'b1, 3'b000, 1'b1, 1'b0); tick();
    apply(3'b000, 5'd0, 1'b0, 3'b000, 1'b1, 1'b1); tick();
    apply(3'b000, 5'd0, 1'b0, 3'b100, 1'b1, 1'b0);
    chk("t6_err_cleared", 64'(issue_err), 64'd0);
    tick();
    for (int c = 0; c < 2; c++) begin
      idle(1'b1);
      chk("t6_no_valid", 64'(wb_valid), 64'd0);
      chk("t6_fdiv_idle", 64'(fdiv_unit_busy), 64'd0);
      tick();
    end

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      int r;
      logic [2:0] st;
      r  = $urandom_range(0, 5);
      st = (r < 3) ? 3'(1 << r) : 3'b000;
      apply(st, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)},
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 59) == 0));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
